// File: rtl/wb_dest_regfile_pkg.sv
// Shared constants and WB source encoding for the back half of the pipeline.
// The control decoder uses the same encoding.
package wb_dest_regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] LINK_REG = 5'd31;

  typedef enum logic [1:0] {
    WB_SRC_ALU  = 2'd0,
    WB_SRC_MEM  = 2'd1,
    WB_SRC_LINK = 2'd2
  } wb_src_e;

  // When both control bits are set, the memory source takes priority.
  function automatic wb_src_e wbSrcSel(input logic memToReg, input logic link);
    if (memToReg)  return WB_SRC_MEM;
    else if (link) return WB_SRC_LINK;
    else           return WB_SRC_ALU;
  endfunction

endpackage

// File: rtl/wb_dest_regfile_regfile_2r1w.sv
// 32-entry general register file with one write port and two combinational
// read ports. Each read port bypasses the same-cycle write.
module regfile_2r1w
  import wb_dest_regfile_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddrA,
  output logic [DW-1:0] rdataA,
  input  logic [AW-1:0] raddrB,
  output logic [DW-1:0] rdataB
);

  logic [DW-1:0] regs_q [1 << AW];
  logic          wrLive;

  // Register 0 is excluded here as well, so it reads 0 on every path.
  assign wrLive = we && (waddr != AW'(REG_ZERO));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < (1 << AW); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wrLive) begin
      regs_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdataA = regs_q[raddrA];
    if (wrLive && (raddrA == waddr)) begin
      rdataA = wdata;
    end
  end

  always_comb begin
    rdataB = regs_q[raddrB];
    if (wrLive && (raddrB == waddr)) begin
      rdataB = wdata;
    end
  end

endmodule

// File: rtl/wb_dest_regfile.sv
// EX/MEM and MEM/WB pipeline registers, the WB source mux and the register file.
// The in-flight destinations are exported to the forwarding and hazard logic.
module wb_dest_regfile
  import wb_dest_regfile_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ex_valid,
  input  logic          flush,
  input  logic [AW-1:0] ex_reg_dest,
  input  logic          ex_reg_write,
  input  logic          ex_mem_to_reg,
  input  logic          ex_link,
  input  logic [DW-1:0] ex_alu_result,
  input  logic [DW-1:0] ex_pc_plus8,
  input  logic [DW-1:0] mem_read_data,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  output logic [AW-1:0] exmem_dest,
  output logic [AW-1:0] memwb_dest,
  output logic          exmem_write,
  output logic          memwb_write,
  output logic [DW-1:0] memwb_wdata
);

  logic [AW-1:0] exmemDest_q;
  logic          exmemWrite_q;
  logic          exmemMemToReg_q;
  logic          exmemLink_q;
  logic [DW-1:0] exmemAlu_q;
  logic [DW-1:0] exmemPc8_q;

  logic [AW-1:0] memwbDest_q;
  logic          memwbWrite_q;
  logic [DW-1:0] memwbWdata_q;

  logic          exmemWrite_d;
  logic [DW-1:0] memwbWdata_d;

  // A squashed or bubble slot still moves down the pipe, just without its write.
  assign exmemWrite_d = ex_reg_write && ex_valid && !flush
                        && (ex_reg_dest != AW'(REG_ZERO));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exmemDest_q     <= '0;
      exmemWrite_q    <= 1'b0;
      exmemMemToReg_q <= 1'b0;
      exmemLink_q     <= 1'b0;
      exmemAlu_q      <= '0;
      exmemPc8_q      <= '0;
    end else begin
      exmemDest_q     <= ex_reg_dest;
      exmemWrite_q    <= exmemWrite_d;
      exmemMemToReg_q <= ex_mem_to_reg;
      exmemLink_q     <= ex_link;
      exmemAlu_q      <= ex_alu_result;
      exmemPc8_q      <= ex_pc_plus8;
    end
  end

  always_comb begin
    memwbWdata_d = exmemAlu_q;
    case (wbSrcSel(exmemMemToReg_q, exmemLink_q))
      WB_SRC_MEM:  memwbWdata_d = mem_read_data;
      WB_SRC_LINK: memwbWdata_d = exmemPc8_q;
      default:     memwbWdata_d = exmemAlu_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memwbDest_q  <= '0;
      memwbWrite_q <= 1'b0;
      memwbWdata_q <= '0;
    end else begin
      memwbDest_q  <= exmemDest_q;
      memwbWrite_q <= exmemWrite_q;
      memwbWdata_q <= memwbWdata_d;
    end
  end

  regfile_2r1w #(
    .DW(DW),
    .AW(AW)
  ) uRegfile (
    .clk    (clk),
    .reset  (reset),
    .we     (memwbWrite_q),
    .waddr  (memwbDest_q),
    .wdata  (memwbWdata_q),
    .raddrA (rs_addr),
    .rdataA (rs_data),
    .raddrB (rt_addr),
    .rdataB (rt_data)
  );

  assign exmem_dest  = exmemDest_q;
  assign exmem_write = exmemWrite_q;
  assign memwb_dest  = memwbDest_q;
  assign memwb_write = memwbWrite_q;
  assign memwb_wdata = memwbWdata_q;

endmodule

// File: tb/tb_wb_dest_regfile.sv
// Directed bench for wb_dest_regfile: R-type, load, JAL, register 0, flush,
// back-to-back writes and an asynchronous reset with instructions in flight.
module tb_wb_dest_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, flush, ex_reg_write, ex_mem_to_reg, ex_link;
  logic [4:0]  ex_reg_dest, rs_addr, rt_addr;
  logic [31:0] ex_alu_result, ex_pc_plus8, mem_read_data;
  logic [31:0] rs_data, rt_data, memwb_wdata;
  logic [4:0]  exmem_dest, memwb_dest;
  logic        exmem_write, memwb_write;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_dest_regfile dut (
    .clk           (clk),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .flush         (flush),
    .ex_reg_dest   (ex_reg_dest),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_link       (ex_link),
    .ex_alu_result (ex_alu_result),
    .ex_pc_plus8   (ex_pc_plus8),
    .mem_read_data (mem_read_data),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .exmem_dest    (exmem_dest),
    .memwb_dest    (memwb_dest),
    .exmem_write   (exmem_write),
    .memwb_write   (memwb_write),
    .memwb_wdata   (memwb_wdata)
  );

  // Compares one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Waits for the next rising edge and settles 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one EX-stage slot and clocks it into EX/MEM.
  task automatic applyStimulus(input logic valid, input logic fl, input logic [4:0] dest,
                               input logic wr, input logic m2r, input logic lnk,
                               input logic [31:0] alu, input logic [31:0] pc8);
    ex_valid      = valid;
    flush         = fl;
    ex_reg_dest   = dest;
    ex_reg_write  = wr;
    ex_mem_to_reg = m2r;
    ex_link       = lnk;
    ex_alu_result = alu;
    ex_pc_plus8   = pc8;
    step();
  endtask

  task automatic bubble();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic readRs(input logic [4:0] addr, input string tag, input logic [31:0] expected);
    rs_addr = addr;
    #1;
    checkOutput(tag, rs_data, expected);
  endtask

  task automatic readRt(input logic [4:0] addr, input string tag, input logic [31:0] expected);
    rt_addr = addr;
    #1;
    checkOutput(tag, rt_data, expected);
  endtask

  initial begin
    reset = 1'b1;
    ex_valid = 0; flush = 0; ex_reg_write = 0; ex_mem_to_reg = 0; ex_link = 0;
    ex_reg_dest = 0; ex_alu_result = 0; ex_pc_plus8 = 0; mem_read_data = 0;
    rs_addr = 0; rt_addr = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset release
    rs_addr = 5'd5;
    rt_addr = 5'd31;
    #1;
    checkOutput("rst_rs5", rs_data, 32'h0);
    checkOutput("rst_rt31", rt_data, 32'h0);
    checkOutput("rst_exmem_write", {31'b0, exmem_write}, 32'h0);
    checkOutput("rst_memwb_write", {31'b0, memwb_write}, 32'h0);

    // R-type to r8
    applyStimulus(1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0);
    checkOutput("rt_exmem_dest", {27'b0, exmem_dest}, 32'd8);
    checkOutput("rt_exmem_write", {31'b0, exmem_write}, 32'h1);
    bubble();
    checkOutput("rt_exmem_write_bubble", {31'b0, exmem_write}, 32'h0);
    checkOutput("rt_memwb_wdata", memwb_wdata, 32'h0000_1234);
    checkOutput("rt_memwb_dest", {27'b0, memwb_dest}, 32'd8);
    checkOutput("rt_memwb_write", {31'b0, memwb_write}, 32'h1);
    readRs(5'd8, "rt_bypass_r8", 32'h0000_1234);
    bubble();
    checkOutput("rt_memwb_write_off", {31'b0, memwb_write}, 32'h0);
    readRs(5'd8, "rt_stored_r8", 32'h0000_1234);

    // Load to r9: memory data must win over the ALU address
    applyStimulus(1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    mem_read_data = 32'hDEAD_BEEF;
    bubble();
    checkOutput("ld_memwb_wdata", memwb_wdata, 32'hDEAD_BEEF);
    mem_read_data = 32'h0;
    bubble();
    readRt(5'd9, "ld_r9", 32'hDEAD_BEEF);

    // JAL to r31
    applyStimulus(1'b1, 1'b0, 5'd31, 1'b1, 1'b0, 1'b1, 32'h0000_0055, 32'h0040_0008);
    bubble();
    checkOutput("jal_memwb_wdata", memwb_wdata, 32'h0040_0008);
    bubble();
    readRt(5'd31, "jal_r31", 32'h0040_0008);

    // mem_to_reg and link both set: memory wins
    applyStimulus(1'b1, 1'b0, 5'd13, 1'b1, 1'b1, 1'b1, 32'h0000_0077, 32'h0000_1111);
    mem_read_data = 32'hCAFE_0000;
    bubble();
    checkOutput("both_memwb_wdata", memwb_wdata, 32'hCAFE_0000);
    mem_read_data = 32'h0;
    bubble();
    readRs(5'd13, "both_r13", 32'hCAFE_0000);

    // Write to r0 is masked
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0);
    checkOutput("zero_exmem_write", {31'b0, exmem_write}, 32'h0);
    bubble();
    readRs(5'd0, "zero_r0_wb", 32'h0);
    bubble();
    readRs(5'd0, "zero_r0", 32'h0);

    // Flushed write to r10 is dropped
    applyStimulus(1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0);
    checkOutput("flush_exmem_write", {31'b0, exmem_write}, 32'h0);
    bubble();
    bubble();
    readRs(5'd10, "flush_r10", 32'h0);

    // Back-to-back writes to r14
    applyStimulus(1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 32'h0000_000A, 32'h0);
    applyStimulus(1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 32'h0000_000B, 32'h0);
    readRs(5'd14, "b2b_first_wb", 32'h0000_000A);
    bubble();
    readRs(5'd14, "b2b_second_wb", 32'h0000_000B);
    bubble();
    readRs(5'd14, "b2b_stored", 32'h0000_000B);

    // Async reset with writes to r11 and r12 in flight
    applyStimulus(1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 32'h0000_0011, 32'h0);
    applyStimulus(1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 32'h0000_0012, 32'h0);
    ex_valid = 1'b0;
    ex_reg_write = 1'b0;
    #1 reset = 1'b1;
    #1;
    checkOutput("ar_exmem_write", {31'b0, exmem_write}, 32'h0);
    checkOutput("ar_memwb_write", {31'b0, memwb_write}, 32'h0);
    checkOutput("ar_memwb_wdata", memwb_wdata, 32'h0);
    checkOutput("ar_exmem_dest", {27'b0, exmem_dest}, 32'h0);
    readRs(5'd8, "ar_r8_cleared", 32'h0);
    #1 reset = 1'b0;
    bubble();
    bubble();
    bubble();
    readRs(5'd11, "ar_r11", 32'h0);
    readRt(5'd12, "ar_r12", 32'h0);
    readRt(5'd31, "ar_r31", 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_dest_regfile.md
Name: wb_dest_regfile

Overview:
- Consumer end of the EX-stage destination-register selection. Carries the selected destination register and its write-enable through the EX/MEM and MEM/WB pipeline registers.
- In WB, chooses the write-back value from ALU result, memory data or link address, and writes the 32-entry general register file.
- Provides the two ID-stage read ports with WB-to-ID bypass, and exports the in-flight destinations to the forwarding/hazard units.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register index width.
- LINK_REG, 31, register index written by jump-and-link.

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all pipeline state and the register file.
- ex_valid  input  1  EX holds a real instruction; 0 = bubble.
- flush  input  1  kill the instruction leaving EX (branch/jump squash).
- ex_reg_dest  input  ADDR_W  destination already selected in EX (rt, rd or LINK_REG).
- ex_reg_write  input  1  instruction writes a register.
- ex_mem_to_reg  input  1  WB value comes from memory.
- ex_link  input  1  WB value is the link address.
- ex_alu_result  input  DATA_W  ALU output.
- ex_pc_plus8  input  DATA_W  link address.
- mem_read_data  input  DATA_W  data-memory output, valid in the MEM cycle.
- rs_addr, rt_addr  input  ADDR_W each  ID read addresses.
- rs_data, rt_data  output  DATA_W each  ID read data.
- exmem_dest, memwb_dest  output  ADDR_W each  in-flight destinations for forwarding.
- exmem_write, memwb_write  output  1 each  qualified write enables for forwarding.
- memwb_wdata  output  DATA_W  WB write value, for forwarding.

Behaviour:
- Reset (async, immediate): all EX/MEM and MEM/WB fields are 0; all 32 registers are 0; every output reads 0.
- EX/MEM capture, every clk edge:
  - Captures dest, mem_to_reg, link, alu_result and pc_plus8.
  - exmem_write = ex_reg_write & ex_valid & ~flush & (ex_reg_dest != 0).
  - flush has priority over ex_valid. A flushed or bubble slot still clocks in its fields, but its write is 0.
- MEM/WB capture, every clk edge:
  - Copies dest and write from EX/MEM.
  - Data = mem_read_data if mem_to_reg; else pc_plus8 if link; else alu_result.
  - If both mem_to_reg and link are 1, mem_to_reg wins.
- WB write: on the clk edge, when memwb_write is 1, regfile[memwb_dest] <= memwb_wdata.
- Register 0:
  - Never written, since the write qualifier already masks dest 0.
  - Always reads 0, including through the bypass path.
- Latency: EX to register-file update is 2 edges (EX/MEM, MEM/WB), and the write lands on the 3rd edge.
- Reads: rs_data/rt_data are combinational.
  - If addr == memwb_dest, memwb_write = 1 and addr != 0, return memwb_wdata (same-cycle WB bypass).
  - Otherwise return the stored value.
- No stall input: the hazard unit inserts bubbles via ex_valid = 0, so the back pipe always advances.
- Reset asserted mid-flight discards both in-flight instructions; no partial write occurs.
- Back-to-back writes to the same register: the later one wins; each is visible in the read port for its own WB cycle.

Decomposition:
- Shared package:
  - REG_ZERO = 0 and LINK_REG = 31.
  - The WB source encoding ALU/MEM/LINK as a 2-bit enum, shared with the control decoder.
  - Data and address width constants.
- One natural sub-module: regfile_2r1w. It holds the 32xDATA_W array, async reset, one write port, and two bypassed combinational read ports.
- The pipeline registers and WB mux stay in the top module.

Test Plan:
- Reset release: read rs = 5 and rt = 31 -> both 0; exmem_write = memwb_write = 0.
- R-type: ex_reg_dest = 8, write = 1, alu = 0x0000_1234, valid = 1. Required response:
  - exmem_dest = 8 after the 1st edge.
  - memwb_wdata = 0x1234 after the 2nd edge.
  - rs_addr = 8 reads 0x1234 combinationally in that cycle (bypass).
  - rs_addr = 8 still reads 0x1234 from storage after the 3rd edge.
- Load: mem_to_reg = 1, dest = 9, alu = 0x40, mem_read_data = 0xDEAD_BEEF during MEM -> reg 9 = 0xDEADBEEF, not 0x40.
- JAL: ex_link = 1, dest = 31, pc_plus8 = 0x0040_0008 -> reg 31 = 0x00400008 after 3 edges.
- Zero and flush:
  - dest = 0, write = 1, alu = 0xFFFF_FFFF -> reg 0 reads 0, exmem_write = 0.
  - Same op to dest = 10 with flush = 1 -> reg 10 unchanged.
- Async reset mid-flight: issue writes to 11 and 12, assert reset between edges -> outputs drop to 0 immediately; no writes after release.
